// File: rtl/wb_arb_pkg.sv
// Shared constants for the write-back arbiter and register scoreboard.
package wb_arb_pkg;

    localparam int unsigned RegAddrW  = 5;
    localparam int unsigned NumRegs   = 32;
    localparam int unsigned DefaultDw = 32;

endpackage

// File: rtl/wb_arb_rr_arb.sv
// Round-robin arbiter: one-hot grant, pointer remembers the last granted index.
module rr_arb #(
    parameter int unsigned N = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o
);

    localparam int unsigned PtrW = (N > 1) ? $clog2(N) : 1;

    logic [PtrW-1:0] ptr_q, ptr_d;

    // Search from ptr+1 upward, wrapping, and grant the first active request.
    always_comb begin
        logic        found;
        int unsigned idx;
        gnt_o = '0;
        ptr_d = ptr_q;
        found = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = (int'(ptr_q) + i) % N;
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                ptr_d      = PtrW'(idx);
                found      = 1'b1;
            end
        end
    end

    // Pointer register; reset to N-1 so the first grant goes to index 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= PtrW'(N - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/wb_arb.sv
// Write-back arbiter with a register scoreboard that stalls issue on hazards.
module wb_arb
    import wb_arb_pkg::*;
#(
    parameter int unsigned DW   = DefaultDw,
    parameter int unsigned NREQ = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               iss_valid,
    input  logic [RegAddrW-1:0]                iss_rd,
    input  logic [RegAddrW-1:0]                iss_rs1,
    input  logic [RegAddrW-1:0]                iss_rs2,
    output logic                               iss_stall,
    input  logic [NREQ-1:0]                    req_valid,
    input  logic [NREQ-1:0][RegAddrW-1:0]      req_rd,
    input  logic [NREQ-1:0][DW-1:0]            req_data,
    output logic [NREQ-1:0]                    req_ready,
    output logic                               rf_wr_en,
    output logic [RegAddrW-1:0]                rf_rd_addr,
    output logic [DW-1:0]                      rf_rd_data,
    output logic [NumRegs-1:0]                 busy
);

    logic [NumRegs-1:0]  busy_q, busy_d;
    logic                rf_wr_en_q, rf_wr_en_d;
    logic [RegAddrW-1:0] rf_rd_addr_q, rf_rd_addr_d;
    logic [DW-1:0]       rf_rd_data_q, rf_rd_data_d;
    logic [NREQ-1:0]     gnt;
    logic                issue;
    logic                xfer;
    logic [RegAddrW-1:0] sel_rd;
    logic [DW-1:0]       sel_data;

    rr_arb #(
        .N (NREQ)
    ) u_rr_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (req_valid),
        .gnt_o (gnt)
    );

    // Hazard check against the scoreboard; bit 0 is never set so x0 never stalls.
    always_comb begin
        iss_stall = iss_valid &
                    (busy_q[iss_rs1] | busy_q[iss_rs2] | busy_q[iss_rd]);
        issue     = iss_valid & ~iss_stall;
    end

    // Mux the granted requester's payload and build next-state for the write stage.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (gnt[i]) begin
                sel_rd   = req_rd[i];
                sel_data = req_data[i];
            end
        end
        xfer         = |gnt;
        rf_wr_en_d   = xfer && (sel_rd != '0);
        rf_rd_addr_d = xfer ? sel_rd : rf_rd_addr_q;
        rf_rd_data_d = xfer ? sel_data : rf_rd_data_q;
    end

    // Scoreboard next state: clear on RF write, then set on issue so set wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_wr_en_q) begin
            busy_d[rf_rd_addr_q] = 1'b0;
        end
        if (issue && (iss_rd != '0)) begin
            busy_d[iss_rd] = 1'b1;
        end
    end

    // State registers; reset also discards any staged write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q       <= '0;
            rf_wr_en_q   <= 1'b0;
            rf_rd_addr_q <= '0;
            rf_rd_data_q <= '0;
        end else begin
            busy_q       <= busy_d;
            rf_wr_en_q   <= rf_wr_en_d;
            rf_rd_addr_q <= rf_rd_addr_d;
            rf_rd_data_q <= rf_rd_data_d;
        end
    end

    assign req_ready  = gnt;
    assign rf_wr_en   = rf_wr_en_q;
    assign rf_rd_addr = rf_rd_addr_q;
    assign rf_rd_data = rf_rd_data_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_wb_arb.sv
// Directed bench for wb_arb: arbitration order, scoreboard hazards, reset.
module tb_wb_arb;

    localparam int unsigned DW   = 32;
    localparam int unsigned NREQ = 3;

    logic                       clk;
    logic                       rst;
    logic                       iss_valid;
    logic [4:0]                 iss_rd, iss_rs1, iss_rs2;
    logic                       iss_stall;
    logic [NREQ-1:0]            req_valid;
    logic [NREQ-1:0][4:0]       req_rd;
    logic [NREQ-1:0][DW-1:0]    req_data;
    logic [NREQ-1:0]            req_ready;
    logic                       rf_wr_en;
    logic [4:0]                 rf_rd_addr;
    logic [DW-1:0]              rf_rd_data;
    logic [31:0]                busy;

    int checks = 0;
    int errors = 0;

    wb_arb #(
        .DW   (DW),
        .NREQ (NREQ)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .iss_rs1    (iss_rs1),
        .iss_rs2    (iss_rs2),
        .iss_stall  (iss_stall),
        .req_valid  (req_valid),
        .req_rd     (req_rd),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rf_wr_en   (rf_wr_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int waited;
        rst       = 1'b1;
        iss_valid = 1'b0;
        iss_rd    = '0;
        iss_rs1   = '0;
        iss_rs2   = '0;
        req_valid = '0;
        req_rd    = '0;
        req_data  = '0;
        tick();
        tick();
        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_wr_en", rf_wr_en, 0);
        chk("rst_addr", rf_rd_addr, 0);
        chk("rst_data", rf_rd_data, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_stall", iss_stall, 0);
        rst = 1'b0;

        // Round robin over all three requesters
        req_rd[0] = 5'd1; req_rd[1] = 5'd2; req_rd[2] = 5'd3;
        req_data[0] = 32'h100; req_data[1] = 32'h101; req_data[2] = 32'h102;
        req_valid = 3'b111;
        #1;
        chk("rr_gnt0", req_ready, 3'b001);
        tick();
        chk("rr_wr1", rf_wr_en, 1);
        chk("rr_addr1", rf_rd_addr, 1);
        chk("rr_data1", rf_rd_data, 32'h100);
        chk("rr_gnt1", req_ready, 3'b010);
        tick();
        chk("rr_addr2", rf_rd_addr, 2);
        chk("rr_gnt2", req_ready, 3'b100);
        tick();
        chk("rr_wr3", rf_wr_en, 1);
        chk("rr_addr3", rf_rd_addr, 3);
        req_valid = '0;
        #1;
        chk("rr_idle_ready", req_ready, 0);
        tick();
        chk("idle_wr_en", rf_wr_en, 0);
        chk("idle_addr_hold", rf_rd_addr, 3);
        chk("idle_data_hold", rf_rd_data, 32'h102);

        // RAW hazard on x5
        iss_valid = 1'b1; iss_rd = 5'd5; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        #1;
        chk("iss5_stall", iss_stall, 0);
        tick();
        chk("iss5_busy", busy, 32'h20);
        iss_rd = 5'd6; iss_rs1 = 5'd5;
        #1;
        chk("raw_stall", iss_stall, 1);
        tick();
        chk("raw_busy_hold", busy, 32'h20);
        req_rd[0] = 5'd5; req_data[0] = 32'h55; req_valid = 3'b001;
        #1;
        chk("wb5_ready", req_ready, 3'b001);
        chk("raw_stall2", iss_stall, 1);
        tick();
        req_valid = '0;
        chk("wb5_wr_en", rf_wr_en, 1);
        chk("wb5_addr", rf_rd_addr, 5);
        chk("raw_stall3", iss_stall, 1);
        tick();
        chk("wb5_busy_clr", busy, 0);
        chk("raw_released", iss_stall, 0);
        tick();
        chk("iss6_busy", busy, 32'h40);
        iss_valid = 1'b0;

        // Write to x0 is accepted and dropped
        req_rd[1] = 5'd0; req_data[1] = 32'hDEAD_BEEF; req_valid = 3'b010;
        #1;
        chk("x0_ready", req_ready, 3'b010);
        tick();
        req_valid = '0;
        chk("x0_wr_en", rf_wr_en, 0);
        chk("x0_busy", busy, 32'h40);
        chk("x0_data", rf_rd_data, 32'hDEAD_BEEF);

        // WAW stall on rd and x0 never stalls
        iss_valid = 1'b1; iss_rd = 5'd7; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
        tick();
        chk("iss7_busy", busy, 32'hC0);
        #1;
        chk("waw_stall", iss_stall, 1);
        tick();
        chk("waw_busy_hold", busy, 32'hC0);
        iss_rd = 5'd0;
        #1;
        chk("rd0_stall", iss_stall, 0);
        tick();
        chk("rd0_busy", busy, 32'hC0);
        iss_valid = 1'b0;

        // Build busy=0xA0: requester 2 writes x6 while x5 issues
        req_rd[2] = 5'd6; req_data[2] = 32'h66; req_valid = 3'b100;
        iss_valid = 1'b1; iss_rd = 5'd5;
        #1;
        chk("b_ready2", req_ready, 3'b100);
        tick();
        req_valid = '0; iss_valid = 1'b0;
        chk("b_busy_e0", busy, 32'hE0);
        tick();
        chk("b_busy_a0", busy, 32'hA0);
        // Stage a write from requester 1, then reset mid-cycle
        req_rd[1] = 5'd9; req_data[1] = 32'h99; req_valid = 3'b010;
        #1;
        chk("stage_ready1", req_ready, 3'b010);
        tick();
        chk("staged_wr_en", rf_wr_en, 1);
        req_rd[0] = 5'd4; req_data[0] = 32'h44; req_valid = 3'b011;
        #1;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_wr_en", rf_wr_en, 0);
        chk("arst_addr", rf_rd_addr, 0);
        chk("arst_data", rf_rd_data, 0);
        chk("arst_ready0", req_ready, 3'b001);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ready0", req_ready, 3'b001);
        tick();
        req_valid = '0;
        chk("post_rst_wr_en", rf_wr_en, 1);
        chk("post_rst_addr", rf_rd_addr, 4);

        // No starvation: requester 0 holds valid, requester 2 joins
        req_rd[2] = 5'd3;
        req_valid = 3'b001;
        #1;
        chk("ns_ready0", req_ready, 3'b001);
        tick();
        req_valid = 3'b101;
        #1;
        waited = 0;
        while (!req_ready[2] && waited < 3) begin
            tick();
            waited++;
        end
        chk("ns_req2_granted", req_ready, 3'b100);
        tick();
        chk("ns_back_to0", req_ready, 3'b001);
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
